// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// requester identifiers used by the arbiter top and its round-robin picker.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Identity of the master owning a one-hot grant vector (M0 when idle).
    function automatic logic grant_owner(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the single-port
// data RAM. The slave modport is the arbiter's view; the master modport is the
// environment's view (both masters plus the RAM read-data return).
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic          m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker. On contention the master that did not win
// last time is chosen; a lone requester always wins. Disabled -> no grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    // One-hot winner selection from the request pair and previous winner.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the CPU load/store unit (m0) and the debug/DMA
// port (m1). One access per cycle, round-robin on contention, with a lock
// mode for read-modify-write that is forcibly released after MAX_LOCK cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

    arb_state_e    state_r, state_nxt_s;
    logic          last_r, last_nxt_s;
    logic [CW-1:0] lock_cnt_r, lock_cnt_nxt_s;
    logic          arb_en_s;
    logic [1:0]    rr_gnt_s;
    logic [1:0]    gnt_s;
    logic [1:0]    gnt_q_s;
    logic          rd0_s, rd1_s;
    logic          rvalid0_r, rvalid1_r;
    logic [DW-1:0] rdata0_r, rdata1_r;

    assign arb_en_s = (state_r == ST_ARB);

    rr_arb2 u_rr (
        .req    ({bus.m1_req, bus.m0_req}),
        .last   (last_r),
        .enable (arb_en_s),
        .gnt    (rr_gnt_s)
    );

    // Grant selection, lock entry/exit and lock-duration counting.
    always_comb begin
        state_nxt_s    = state_r;
        last_nxt_s     = last_r;
        lock_cnt_nxt_s = lock_cnt_r;
        gnt_s          = 2'b00;
        case (state_r)
            ST_ARB: begin
                gnt_s          = rr_gnt_s;
                lock_cnt_nxt_s = {CW{1'b0}};
                if (rr_gnt_s != 2'b00) begin
                    last_nxt_s = grant_owner(rr_gnt_s);
                    if (rr_gnt_s[0] && bus.m0_lock) begin
                        state_nxt_s = ST_LOCK0;
                    end else if (rr_gnt_s[1] && bus.m1_lock) begin
                        state_nxt_s = ST_LOCK1;
                    end else begin
                        state_nxt_s = ST_ARB;
                    end
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_LOCK0: begin
                gnt_s = {1'b0, bus.m0_req};
                if ((bus.m0_req && !bus.m0_lock) || (lock_cnt_r == CNT_LAST)) begin
                    state_nxt_s    = ST_ARB;
                    last_nxt_s     = M0;
                    lock_cnt_nxt_s = {CW{1'b0}};
                end else if (lock_cnt_r != CNT_LAST) begin
                    lock_cnt_nxt_s = lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
            end
            ST_LOCK1: begin
                gnt_s = {bus.m1_req, 1'b0};
                if ((bus.m1_req && !bus.m1_lock) || (lock_cnt_r == CNT_LAST)) begin
                    state_nxt_s    = ST_ARB;
                    last_nxt_s     = M1;
                    lock_cnt_nxt_s = {CW{1'b0}};
                end else if (lock_cnt_r != CNT_LAST) begin
                    lock_cnt_nxt_s = lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_ARB;
                last_nxt_s     = M1;
                lock_cnt_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // Grants are suppressed while reset is asserted so the RAM sees no access.
    assign gnt_q_s    = gnt_s & {2{rst_n}};
    assign bus.m0_gnt = gnt_q_s[0];
    assign bus.m1_gnt = gnt_q_s[1];
    assign rd0_s      = gnt_q_s[0] & ~bus.m0_we;
    assign rd1_s      = gnt_q_s[1] & ~bus.m1_we;

    // RAM command mux: granted master's request, all zero when idle.
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = {DW{1'b0}};
        if (gnt_q_s[0]) begin
            bus.mem_read  = ~bus.m0_we;
            bus.mem_write = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
        end else if (gnt_q_s[1]) begin
            bus.mem_read  = ~bus.m1_we;
            bus.mem_write = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
        end else begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    end

    // Arbitration state, round-robin history and lock counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_ARB;
            last_r     <= M1;
            lock_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
        end
    end

    // Read-data capture: RAM data sampled only on a granted read, then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= {DW{1'b0}};
            rdata1_r  <= {DW{1'b0}};
        end else begin
            rvalid0_r <= rd0_s;
            rvalid1_r <= rd1_s;
            if (rd0_s) begin
                rdata0_r <= bus.mem_rdata;
            end
            if (rd1_s) begin
                rdata1_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_rvalid = rvalid0_r;
    assign bus.m1_rvalid = rvalid1_r;
    assign bus.m0_rdata  = rdata0_r;
    assign bus.m1_rdata  = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, contention, write/read, locked
// read-modify-write, lock timeout, back-to-back writes and mid-lock reset.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 16;

    logic        clk;
    logic        rst_n;
    logic        ram_load;
    logic [31:0] ram [0:255];
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed RAM model: preloaded pattern, synchronous write.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + i;
        end else if (bus.mem_write) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = bus.mem_read ? ram[bus.mem_addr[9:2]] : {DW{1'bz}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
        bus.m0_addr = addr; bus.m0_wdata = wdata;
    endtask

    task automatic drv1(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
        bus.m1_addr = addr; bus.m1_wdata = wdata;
    endtask

    initial begin
        rst_n    = 1'b0;
        ram_load = 1'b1;
        drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        @(posedge clk);
        next_cycle();
        // Reset held with both masters requesting
        chk("rst_gnt0", bus.m0_gnt, 32'h0);
        chk("rst_gnt1", bus.m1_gnt, 32'h0);
        chk("rst_mem_read", bus.mem_read, 32'h0);
        chk("rst_rvalid0", bus.m0_rvalid, 32'h0);
        chk("rst_rdata0", bus.m0_rdata, 32'h0);
        drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        ram_load = 1'b0;
        rst_n    = 1'b1;

        // Contention: alternating grants starting with m0
        next_cycle();
        drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        #1;
        chk("cont_a_gnt0", bus.m0_gnt, 32'h1);
        chk("cont_a_gnt1", bus.m1_gnt, 32'h0);
        chk("cont_a_addr", bus.mem_addr, 32'h0);
        next_cycle(); #1;
        chk("cont_b_gnt0", bus.m0_gnt, 32'h0);
        chk("cont_b_gnt1", bus.m1_gnt, 32'h1);
        chk("cont_b_addr", bus.mem_addr, 32'h4);
        chk("cont_b_rvalid0", bus.m0_rvalid, 32'h1);
        chk("cont_b_rdata0", bus.m0_rdata, 32'h1000_0000);
        chk("cont_b_rvalid1", bus.m1_rvalid, 32'h0);
        next_cycle(); #1;
        chk("cont_c_gnt0", bus.m0_gnt, 32'h1);
        chk("cont_c_gnt1", bus.m1_gnt, 32'h0);
        chk("cont_c_rvalid1", bus.m1_rvalid, 32'h1);
        chk("cont_c_rdata1", bus.m1_rdata, 32'h1000_0001);
        chk("cont_c_rvalid0", bus.m0_rvalid, 32'h0);
        next_cycle(); #1;
        chk("cont_d_gnt1", bus.m1_gnt, 32'h1);
        chk("cont_d_gnt0", bus.m0_gnt, 32'h0);

        // m1 write then m0 read of the same word
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("wr_gnt1", bus.m1_gnt, 32'h1);
        chk("wr_mem_write", bus.mem_write, 32'h1);
        chk("wr_mem_read", bus.mem_read, 32'h0);
        chk("wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("rd_gnt0", bus.m0_gnt, 32'h1);
        chk("rd_mem_read", bus.mem_read, 32'h1);

        // Locked read-modify-write on 0x20 while m1 waits
        next_cycle();
        drv0(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        #1;
        chk("rd_rvalid0", bus.m0_rvalid, 32'h1);
        chk("rd_rdata0", bus.m0_rdata, 32'hDEAD_BEEF);
        chk("lk_rd_gnt0", bus.m0_gnt, 32'h1);
        next_cycle();
        drv0(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
        #1;
        chk("lk_idle_gnt1", bus.m1_gnt, 32'h0);
        chk("lk_idle_gnt0", bus.m0_gnt, 32'h0);
        chk("lk_idle_mem_read", bus.mem_read, 32'h0);
        chk("lk_rdata0", bus.m0_rdata, 32'h1000_0008);
        next_cycle();
        drv0(1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFE_0001);
        #1;
        chk("lk_wr_gnt0", bus.m0_gnt, 32'h1);
        chk("lk_wr_gnt1", bus.m1_gnt, 32'h0);
        chk("lk_wr_mem_write", bus.mem_write, 32'h1);
        chk("lk_rdata0_held", bus.m0_rdata, 32'h1000_0008);
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("unlk_gnt1", bus.m1_gnt, 32'h1);
        chk("unlk_addr", bus.mem_addr, 32'h24);
        chk("rmw_ram", ram[8], 32'hCAFE_0001);

        // Lock timeout: m0 locks then idles, m1 held off for MAX_LOCK cycles
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv0(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
        #1;
        chk("to_lock_gnt0", bus.m0_gnt, 32'h1);
        chk("to_rdata1", bus.m1_rdata, 32'h1000_0009);
        for (int i = 1; i <= MAX_LOCK; i++) begin
            next_cycle();
            if (i == 1) begin
                drv0(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
                drv1(1'b1, 1'b0, 1'b0, 32'h34, 32'h0);
            end
            #1;
            chk("to_stall_gnt1", bus.m1_gnt, 32'h0);
        end
        next_cycle(); #1;
        chk("to_release_gnt1", bus.m1_gnt, 32'h1);
        chk("to_release_addr", bus.mem_addr, 32'h34);

        // m1 alone: four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drv1(1'b1, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
            #1;
            chk("b2b_gnt1", bus.m1_gnt, 32'h1);
            chk("b2b_mem_write", bus.mem_write, 32'h1);
        end
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ram", ram[16 + i], 32'hA5A5_0000 + 32'(i));
        end

        // Reset in the middle of a lock
        next_cycle();
        drv0(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        #1;
        chk("mr_lock_gnt0", bus.m0_gnt, 32'h1);
        next_cycle();
        drv0(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        #1;
        chk("mr_locked_gnt1", bus.m1_gnt, 32'h0);
        chk("mr_rvalid0", bus.m0_rvalid, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_gnt0", bus.m0_gnt, 32'h0);
        chk("mr_rst_gnt1", bus.m1_gnt, 32'h0);
        chk("mr_rst_rvalid0", bus.m0_rvalid, 32'h0);
        chk("mr_rst_rdata0", bus.m0_rdata, 32'h0);
        chk("mr_rst_mem_read", bus.mem_read, 32'h0);
        chk("mr_rst_mem_write", bus.mem_write, 32'h0);
        #4;
        rst_n = 1'b1;
        next_cycle(); #1;
        chk("mr_after_gnt1", bus.m1_gnt, 32'h1);
        next_cycle();
        drv0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("mr_contend_gnt0", bus.m0_gnt, 32'h1);
        chk("mr_contend_gnt1", bus.m1_gnt, 32'h0);

        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
